// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types for the MEM/WB stage register family.
package pipe_pkg;

    // Register index hard-wired to zero; writes to it never reach the file.
    localparam int ZERO_REG_IDX = 31;

    // Default datapath and register-address widths.
    localparam int DEFAULT_DATA_W = 64;
    localparam int DEFAULT_ADDR_W = 5;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

endpackage : pipe_pkg

// File: rtl/register.sv
// Generic W-bit enabled register with synchronous active-high clear.
module register #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] Din,
    output logic [W-1:0] Dout
);

    // Clear on reset, otherwise capture Din when enabled.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            Dout <= '0;
        end else if (enable) begin
            Dout <= Din;
        end
    end

endmodule : register

// File: rtl/pipe_wb_stage_reg.sv
// MEM->WB pipeline stage register with valid, stall/flush, write-enable
// qualification, per-source forwarding hits and a saturating stall counter.
module pipe_wb_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = ZERO_REG_IDX,
    parameter int NUM_SRC  = 2,
    parameter int CNT_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic                      regwrite_en_in,
    input  logic [DATA_W-1:0]         wdata_in,
    input  logic [ADDR_W-1:0]         rd_in,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    output logic                      valid_out,
    output logic                      regwrite_en_out,
    output logic [DATA_W-1:0]         wdata_out,
    output logic [ADDR_W-1:0]         rd_out,
    output logic [NUM_SRC-1:0]        fwd_hit,
    output logic [CNT_W-1:0]          stall_cycles
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // Payload only moves on a plain load; a flush leaves it untouched because
    // it is meaningless once the entry is marked invalid.
    logic data_en;
    logic wen_qualified;

    assign data_en       = ~(stall | flush);
    assign wen_qualified = regwrite_en_in & valid_in & (rd_in != ZERO_ADDR);

    // NOTE: the data registers are reset as well, so rd_out/wdata_out read 0
    // out of reset instead of X, keeping downstream comparators well defined.
    register #(.W(DATA_W)) u_wdata_reg (
        .clk    (clk),
        .reset  (reset),
        .enable (data_en),
        .Din    (wdata_in),
        .Dout   (wdata_out)
    );

    register #(.W(ADDR_W)) u_rd_reg (
        .clk    (clk),
        .reset  (reset),
        .enable (data_en),
        .Din    (rd_in),
        .Dout   (rd_out)
    );

    // Control bits: reset > flush (bubble) > stall (hold) > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out       <= 1'b0;
            regwrite_en_out <= 1'b0;
        end else if (flush) begin
            valid_out       <= 1'b0;
            regwrite_en_out <= 1'b0;
        end else if (!stall) begin
            valid_out       <= valid_in;
            regwrite_en_out <= wen_qualified;
        end
    end

    // Count consecutive stalled edges, saturating; any non-stall edge clears.
    always_ff @(posedge clk) begin
        if (reset || flush || !stall) begin
            stall_cycles <= '0;
        end else if (stall_cycles != CNT_MAX) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // Forwarding hits depend only on registered state and the source ports.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        assign fwd_hit[i] = regwrite_en_out & (rd_out == src_addr[i*ADDR_W +: ADDR_W]);
    end

endmodule : pipe_wb_stage_reg

// File: tb/tb_pipe_wb_stage_reg.sv
// Directed self-checking bench for pipe_wb_stage_reg (default parameters).
module tb_pipe_wb_stage_reg;
    import pipe_pkg::*;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 5;
    localparam int NUM_SRC = 2;
    localparam int CNT_W   = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      stall;
    logic                      flush;
    logic                      valid_in;
    logic                      regwrite_en_in;
    logic [DATA_W-1:0]         wdata_in;
    logic [ADDR_W-1:0]         rd_in;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic                      valid_out;
    logic                      regwrite_en_out;
    logic [DATA_W-1:0]         wdata_out;
    logic [ADDR_W-1:0]         rd_out;
    logic [NUM_SRC-1:0]        fwd_hit;
    logic [CNT_W-1:0]          stall_cycles;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_wb_stage_reg dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .valid_in        (valid_in),
        .regwrite_en_in  (regwrite_en_in),
        .wdata_in        (wdata_in),
        .rd_in           (rd_in),
        .src_addr        (src_addr),
        .valid_out       (valid_out),
        .regwrite_en_out (regwrite_en_out),
        .wdata_out       (wdata_out),
        .rd_out          (rd_out),
        .fwd_hit         (fwd_hit),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input reg_addr_t s1, input reg_addr_t s0);
        src_addr = {s1, s0};
    endtask

    task automatic load(input logic [4:0] rd, input logic [63:0] data);
        valid_in       = 1'b1;
        regwrite_en_in = 1'b1;
        rd_in          = rd;
        wdata_in       = data;
    endtask

    initial begin
        // 1. Reset with random inputs, then first load.
        reset          = 1'b1;
        stall          = 1'b0;
        flush          = 1'b0;
        valid_in       = 1'b1;
        regwrite_en_in = 1'b1;
        wdata_in       = {$urandom, $urandom};
        rd_in          = 5'($urandom);
        src_addr       = 10'($urandom);
        tick();
        wdata_in = {$urandom, $urandom};
        rd_in    = 5'($urandom);
        stall    = 1'($urandom);
        tick();
        check("rst_valid", 64'(valid_out), 64'(0));
        check("rst_wen",   64'(regwrite_en_out), 64'(0));
        check("rst_wdata", wdata_out, 64'(0));
        check("rst_rd",    64'(rd_out), 64'(0));
        check("rst_cnt",   64'(stall_cycles), 64'(0));
        check("rst_fwd",   64'(fwd_hit), 64'(0));

        reset = 1'b0;
        stall = 1'b0;
        load(5'd5, 64'hDEAD_BEEF);
        tick();
        check("ld_valid", 64'(valid_out), 64'(1));
        check("ld_wen",   64'(regwrite_en_out), 64'(1));
        check("ld_rd",    64'(rd_out), 64'(5));
        check("ld_wdata", wdata_out, 64'hDEAD_BEEF);

        // 2. Zero-register write is suppressed and never forwards.
        load(5'd31, 64'h1111);
        tick();
        check("zr_wen",   64'(regwrite_en_out), 64'(0));
        check("zr_valid", 64'(valid_out), 64'(1));
        check("zr_rd",    64'(rd_out), 64'(31));
        set_src(5'd31, 5'd31);
        #1;
        check("zr_fwd", 64'(fwd_hit), 64'(0));

        // Invalid instruction with write enable must not write.
        valid_in = 1'b0;
        rd_in    = 5'd6;
        tick();
        check("inv_valid", 64'(valid_out), 64'(0));
        check("inv_wen",   64'(regwrite_en_out), 64'(0));

        // 3. Long stall: hold contents, counter saturates at 15.
        load(5'd7, 64'h7777);
        set_src(5'd0, 5'd0);
        tick();
        check("st_pre_rd", 64'(rd_out), 64'(7));
        stall = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            rd_in    = 5'(k);
            wdata_in = {$urandom, $urandom};
            valid_in = 1'($urandom);
            tick();
            check("st_rd",    64'(rd_out), 64'(7));
            check("st_wdata", wdata_out, 64'h7777);
            check("st_wen",   64'(regwrite_en_out), 64'(1));
            check("st_cnt",   64'(stall_cycles), 64'((k > 15) ? 15 : k));
        end
        stall = 1'b0;
        load(5'd8, 64'h8888);
        tick();
        check("unst_cnt",   64'(stall_cycles), 64'(0));
        check("unst_rd",    64'(rd_out), 64'(8));
        check("unst_wdata", wdata_out, 64'h8888);

        // 4. Flush beats a simultaneous stall and clears the counter.
        load(5'd9, 64'h9999);
        tick();
        check("fl_pre_wen", 64'(regwrite_en_out), 64'(1));
        stall = 1'b1;
        tick();
        check("fl_pre_cnt", 64'(stall_cycles), 64'(1));
        flush = 1'b1;
        tick();
        check("fl_valid", 64'(valid_out), 64'(0));
        check("fl_wen",   64'(regwrite_en_out), 64'(0));
        check("fl_cnt",   64'(stall_cycles), 64'(0));
        set_src(5'd9, 5'd9);
        #1;
        check("fl_fwd", 64'(fwd_hit), 64'(0));

        // 5. Per-slot forwarding hits, combinational in src_addr only.
        stall = 1'b0;
        flush = 1'b0;
        load(5'd12, 64'hC0C0);
        tick();
        set_src(5'd3, 5'd12);
        #1;
        check("fwd_slot0", 64'(fwd_hit), 64'(2'b01));
        set_src(5'd12, 5'd4);
        #1;
        check("fwd_slot1", 64'(fwd_hit), 64'(2'b10));
        set_src(5'd12, 5'd12);
        #1;
        check("fwd_both", 64'(fwd_hit), 64'(2'b11));
        set_src(5'd12, 5'd4);
        rd_in = 5'd4;
        #1;
        check("fwd_rdin", 64'(fwd_hit), 64'(2'b10));

        // Back-to-back writes to the same rd: newest value wins.
        load(5'd12, 64'hAAAA);
        tick();
        load(5'd12, 64'hBBBB);
        tick();
        check("b2b_wdata", wdata_out, 64'hBBBB);

        // 6. Reset asserted in the middle of a stall.
        load(5'd2, 64'h2222);
        tick();
        stall = 1'b1;
        repeat (3) tick();
        check("rs_cnt", 64'(stall_cycles), 64'(3));
        check("rs_rd",  64'(rd_out), 64'(2));
        reset = 1'b1;
        tick();
        check("rs_valid", 64'(valid_out), 64'(0));
        check("rs_wen",   64'(regwrite_en_out), 64'(0));
        check("rs_rd0",   64'(rd_out), 64'(0));
        check("rs_wdata", wdata_out, 64'(0));
        check("rs_cnt0",  64'(stall_cycles), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pipe_wb_stage_reg
